seg_pipe_adder: RTL
===================

# seg_pipe_adder

Parametrised, pipelined ripple-carry adder: the WIDTH-bit operands are split into SEG-bit segments and one segment is resolved per clock, with the carry registered between stages. This gives one addition per cycle at a clock rate set by a SEG-bit ripple rather than a WIDTH-bit ripple. A valid/ready handshake on both sides lets the block sit between streaming datapath stages. It also reports unsigned carry-out and signed overflow.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, and STAGES ≥ 1.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  A/B/Cin (and Sub) are valid this cycle.
- in_ready  output  1  block can accept an operand pair this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry into bit 0.
- Sub  input  1  subtract mode; present only with SEG_PIPE_ADDER_SUB_EN.
- out_valid  output  1  Sum/Cout/Ovf hold a result.
- out_ready  input  1  downstream accepts the result this cycle.
- Sum  output  WIDTH  A+B+Cin mod 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.
- Ovf  output  1  two's-complement overflow: carry into MSB XOR Cout.

## Operation
- Accept: in_valid && in_ready at edge t.
- Stage k (0..STAGES-1) adds segment k of the operands plus the carry registered from stage k-1. Stage 0 uses Cin.
- Operand segments not yet consumed travel down skew registers. Completed sum segments travel down deskew registers, so all WIDTH bits of Sum emerge together.
- Ovf is computed in the last stage from the carry into bit WIDTH-1 and Cout.
- Per-stage valid bits form a shift chain. out_valid is the last stage's valid.
- Stall = out_valid && !out_ready.
  - Stall freezes every stage register, including valid bits.
  - in_ready = !stall. This is a global stall: no bubble collapsing.
- When not stalled, a stage holding no transaction shifts in a bubble (valid 0). Datapath contents under valid 0 are don't-care.
- Sum/Cout/Ovf are stable and unchanged while out_valid && !out_ready.
- Inputs are ignored when in_valid is 0 or in_ready is 0.

## Timing
- Latency: a transaction accepted at edge t has out_valid = 1 after edge t+STAGES, absent stalls. Each stall cycle adds one cycle.
- Throughput: one transaction per cycle with out_ready held high.
- STAGES = 1 degenerates to a fully registered adder with latency 1.
- Reset (rst_n low at an edge):
  - All valid bits clear, so out_valid = 0.
  - Sum = 0, Cout = 0, Ovf = 0; all pipeline data registers clear.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight transactions with no output. Reset has priority over the handshake in the same cycle.
- Simultaneous accept and output in one cycle is legal when not stalled.
- in_ready depends combinationally on out_ready. out_ready has no combinational path to any data output.

## Configuration
- SEG_PIPE_ADDER_SUB_EN defined:
  - Sub port exists and is sampled with A/B at acceptance.
  - Sub = 1 computes A + ~B + 1; Cin is ignored in that transaction.
  - Cout = 1 means no borrow.
  - Ovf is signed subtraction overflow.
- Not defined: no Sub port; the block always computes A+B+Cin.

## Structure
- Shared package adder_pkg holds:
  - default WIDTH/SEG constants;
  - a function returning STAGES;
  - an elaboration check that WIDTH % SEG == 0.
- Sub-module seg_adder_stage: combinational SEG-bit ripple adder built from the existing full-adder cell. Inputs are a, b and cin; outputs are sum, cout and the carry into its MSB. The top instantiates it STAGES times through a generate loop.

## Test plan
Cases 1–5 use WIDTH = 16, SEG = 4.
- 0x7FFF + 0x0001, Cin 0 → Sum 0x8000, Cout 0, Ovf 1; out_valid exactly 4 cycles after acceptance.
- 0xFFFF + 0x0001, Cin 0 → Sum 0x0000, Cout 1, Ovf 0. Then 0x00FF + 0x0000, Cin 1 → Sum 0x0100, Cout 0, Ovf 0. This exercises full carry ripple across every segment.
- 8 back-to-back random transactions with out_ready low for 3 cycles mid-stream:
  - results emerge in order, each matching a reference model;
  - none is dropped or duplicated;
  - in_ready is low exactly during the 3 stall cycles.
- Reset asserted with 3 transactions in flight → out_valid 0 on the next cycle and stays 0. The next accepted 0x1234 + 0x1111 → Sum 0x2345.
- With SEG_PIPE_ADDER_SUB_EN:
  - 0x0005 − 0x0007 → Sum 0xFFFE, Cout 0, Ovf 0;
  - 0x8000 − 0x0001 → Sum 0x7FFF, Cout 1, Ovf 1.
- WIDTH = 8, SEG = 8 (STAGES = 1): 0xC8 + 0x64 → Sum 0x2C, Cout 1, Ovf 0; latency 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Also holds the WIDTH/SEG legality check used at elaboration.
package adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_SEG   = 4;

    function automatic int num_stages(input int w, input int s);
        return w / s;
    endfunction

    function automatic bit seg_ok(input int w, input int s);
        return (s > 0) && (w >= s) && ((w % s) == 0);
    endfunction

    localparam bit DEFAULT_CFG_OK = seg_ok(ADD_WIDTH, ADD_SEG);

endpackage

// File: rtl/seg_adder_stage.sv
// SEG-bit combinational ripple slice built from fa_cell.
// One slice is resolved per pipeline stage of seg_pipe_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));
endmodule

module seg_adder_stage
    import adder_pkg::*;
#(
    parameter int SEG = ADD_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);
    logic [SEG:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SEG; i++) begin : g_fa
        fa_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .cin(w_c[i]),
            .s  (sum[i]),
            .co (w_c[i+1])
        );
    end

    assign cout = w_c[SEG];
    assign cmsb = w_c[SEG-1];
endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined ripple adder resolving SEG bits per clock with valid/ready.
// Define SEG_PIPE_ADDER_SUB_EN to add the Sub port (A + ~B + 1).
module seg_pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SEG   = ADD_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SEG_PIPE_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int STAGES = num_stages(WIDTH, SEG);

    if (!seg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("seg_pipe_adder: WIDTH must be a nonzero multiple of SEG");
    end

    // r_x[l] = {operand A bits not yet consumed, sum bits already resolved}
    logic [STAGES:0]  r_v;
    logic [STAGES:0]  r_c;
    logic [WIDTH-1:0] r_x [0:STAGES];
    logic [WIDTH-1:0] r_b [0:STAGES-1];
    logic             r_ovf;

    logic [SEG-1:0]    w_sum [0:STAGES-1];
    logic [STAGES-1:0] w_co;
    logic [STAGES-1:0] w_cm;
    logic [WIDTH-1:0]  w_b_in;
    logic              w_c_in;
    logic              w_stall;

`ifdef SEG_PIPE_ADDER_SUB_EN
    assign w_b_in = Sub ? ~B : B;
    assign w_c_in = Sub ? 1'b1 : Cin;
`else
    assign w_b_in = B;
    assign w_c_in = Cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        seg_adder_stage #(.SEG(SEG)) u_stg (
            .a   (r_x[k][k*SEG +: SEG]),
            .b   (r_b[k][SEG-1:0]),
            .cin (r_c[k]),
            .sum (w_sum[k]),
            .cout(w_co[k]),
            .cmsb(w_cm[k])
        );
    end

    assign w_stall  = r_v[STAGES] && !out_ready;
    assign in_ready = !w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int l = 0; l <= STAGES; l++) r_x[l] <= '0;
            for (int l = 0; l < STAGES; l++)  r_b[l] <= '0;
        end else if (!w_stall) begin
            r_v    <= {r_v[STAGES-1:0], in_valid};
            r_c[0] <= w_c_in;
            r_x[0] <= A;
            r_b[0] <= w_b_in;
            for (int k = 0; k < STAGES; k++) begin
                r_x[k+1]               <= r_x[k];
                r_x[k+1][k*SEG +: SEG] <= w_sum[k];
                r_c[k+1]               <= w_co[k];
            end
            // B is pre-shifted so each stage always reads its low segment
            for (int k = 1; k < STAGES; k++) r_b[k] <= r_b[k-1] >> SEG;
            r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
        end
    end

    assign out_valid = r_v[STAGES];
    assign Sum       = r_x[STAGES];
    assign Cout      = r_c[STAGES];
    assign Ovf       = r_ovf;
endmodule
